// File: rtl/xor_parity_serializer.sv
// xor_parity_serializer: sends a parallel word LSB first over a valid/ready serial beat stream,
// then one beat carrying the XOR parity of the word.
module xor_parity_serializer #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic [CW-1:0]     count;
    logic              last_bit;

    assign last_bit = (count == CW'(DATA_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = (ser_ready && last_bit) ? PARITY : SHIFT;
            PARITY:  state_nxt = ser_ready ? IDLE : PARITY;
            default: state_nxt = IDLE;
        endcase
    end

    // acc starts at the parity mode so the final beat is already odd/even corrected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            acc   <= 1'b0;
            count <= '0;
        end else if (state == IDLE && in_valid) begin
            shreg <= in_data;
            acc   <= PARITY_ODD;
            count <= '0;
        end else if (state == SHIFT && ser_ready) begin
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            count <= count + CW'(1);
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        ser_valid = (state != IDLE);
        ser_last  = (state == PARITY);
        ser_out   = (state == SHIFT) ? shreg[0] : (state == PARITY) ? acc : 1'b0;
    end
endmodule

// File: tb/tb_xor_parity_serializer.sv
// tb_xor_parity_serializer: directed frames against an even and an odd parity instance,
// checked every cycle against a beat-queue model and per frame against literal frames.
module tb_xor_parity_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         ser_ready = 1'b0;
    logic         in_ready0, ser_out0, ser_valid0, ser_last0;
    logic         in_ready1, ser_out1, ser_valid1, ser_last1;

    int tests = 0;
    int fails = 0;

    xor_parity_serializer #(.DATA_W(W), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_last(ser_last0));

    xor_parity_serializer #(.DATA_W(W), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_last(ser_last1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is the queue of beats still to be sent (data LSB first, then even parity).
    // Empty queue means idle; a word is taken only when the queue is empty.
    logic q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (q.size() == 0) begin
            if (in_valid) begin
                for (int i = 0; i < W; i++) q.push_back(in_data[i]);
                q.push_back(^in_data);
            end
        end else if (ser_ready) void'(q.pop_front());
    end

    always @(negedge clk) begin
        logic busy, lst, b0, b1;
        busy = (q.size() != 0);
        lst  = (q.size() == 1);
        b0   = busy ? q[0] : 1'b0;
        b1   = busy ? (q[0] ^ lst) : 1'b0;
        chk("in_ready0",  {8'd0, in_ready0},  {8'd0, !busy});
        chk("ser_valid0", {8'd0, ser_valid0}, {8'd0, busy});
        chk("ser_last0",  {8'd0, ser_last0},  {8'd0, lst});
        chk("ser_out0",   {8'd0, ser_out0},   {8'd0, b0});
        chk("in_ready1",  {8'd0, in_ready1},  {8'd0, !busy});
        chk("ser_valid1", {8'd0, ser_valid1}, {8'd0, busy});
        chk("ser_last1",  {8'd0, ser_last1},  {8'd0, lst});
        chk("ser_out1",   {8'd0, ser_out1},   {8'd0, b1});
    end

    // Capture accepted beats into {parity, data} frames for the literal checks
    logic [8:0] fr0, fr1;
    logic [8:0] frames0[$], frames1[$];
    int         n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n   = 0;
            fr0 = '0;
            fr1 = '0;
        end else if (ser_valid0 && ser_ready) begin
            if (n < 9) begin
                fr0[n] = ser_out0;
                fr1[n] = ser_out1;
            end
            n++;
            if (ser_last0) begin
                frames0.push_back(fr0);
                frames1.push_back(fr1);
                n = 0;
            end
        end
    end

    task automatic expect_frame(input string nm, input logic [8:0] e0, input logic [8:0] e1);
        logic [8:0] a0, a1;
        a0 = 9'h1ff;
        a1 = 9'h1ff;
        if (frames0.size() != 0) a0 = frames0.pop_front();
        if (frames1.size() != 0) a1 = frames1.pop_front();
        chk({nm, " even"}, a0, e0);
        chk({nm, " odd"},  a1, e1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h3c;
    endtask

    initial begin
        int zeros;
        #3;
        chk("reset in_ready",  {8'd0, in_ready0},  9'd1);
        chk("reset ser_valid", {8'd0, ser_valid0}, 9'd0);
        chk("reset ser_out",   {8'd0, ser_out0},   9'd0);
        chk("reset ser_last",  {8'd0, ser_last0},  9'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ser_ready = 1'b1;
        tick();

        send(8'ha5);
        repeat (9) tick();
        chk("a5 in_ready back", {8'd0, in_ready0}, 9'd1);
        expect_frame("a5", 9'h0a5, 9'h1a5);

        send(8'h07);
        repeat (9) tick();
        expect_frame("07", 9'h107, 9'h007);

        send(8'ha5);
        tick();
        tick();
        ser_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("stall ser_out",   {8'd0, ser_out0},   9'd1);
            chk("stall ser_valid", {8'd0, ser_valid0}, 9'd1);
        end
        ser_ready = 1'b1;
        repeat (7) tick();
        expect_frame("a5 stalled", 9'h0a5, 9'h1a5);

        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        in_data = 8'hff;
        repeat (4) begin
            tick();
            chk("busy in_ready", {8'd0, in_ready0}, 9'd0);
        end
        repeat (5) tick();
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        expect_frame("00 under ff", 9'h000, 9'h100);
        expect_frame("ff after 00", 9'h0ff, 9'h1ff);

        zeros = 0;
        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        if (!ser_valid0) zeros++;
        in_data = 8'hff;
        repeat (18) begin
            tick();
            if (!ser_valid0) zeros++;
        end
        in_valid = 1'b0;
        tick();
        chk("b2b idle gap", 9'(zeros), 9'd1);
        expect_frame("b2b 00", 9'h000, 9'h100);
        expect_frame("b2b ff", 9'h0ff, 9'h1ff);

        send(8'ha5);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ser_valid", {8'd0, ser_valid0}, 9'd0);
        chk("async rst ser_out",   {8'd0, ser_out0},   9'd0);
        chk("async rst ser_last",  {8'd0, ser_last0},  9'd0);
        chk("async rst in_ready",  {8'd0, in_ready0},  9'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h07);
        repeat (9) tick();
        expect_frame("07 after rst", 9'h107, 9'h007);
        chk("no extra frames", 9'(frames0.size() + frames1.size()), 9'd0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/xor_parity_serializer.md
Name: xor_parity_serializer

Overview:
Parity-framing stage that consumes parallel words and emits them as a serial bitstream, LSB first, with an XOR-accumulated parity bit appended. It sits upstream of the serial link and parity checker. It shares the XOR reduction used by the gate-level xor_gate cell. Both sides use valid/ready handshakes, so the block can be stalled by a slower downstream consumer.

Parameters:
- DATA_W, 8, word width in bits; legal range DATA_W >= 2.
- PARITY_ODD, 0, parity mode: 0 = even parity, 1 = odd parity. Sets the initial value of the parity accumulator.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data holds a word to be sent.
- in_data, input, DATA_W, parallel word.
- in_ready, output, 1, block can accept a word; high only in IDLE.
- ser_out, output, 1, current serial bit.
- ser_valid, output, 1, ser_out is a valid beat.
- ser_ready, input, 1, downstream accepts the current beat.
- ser_last, output, 1, current beat is the parity bit, i.e. the final beat of the frame.

Behaviour:
- Reset values while rst_n=0, taking effect immediately (asynchronous):
  - state = IDLE; shift register = 0; parity accumulator = 0; bit counter = 0.
  - ser_valid = 0, ser_out = 0, ser_last = 0, in_ready = 1.
- Reset asserted mid-frame aborts the frame. No partial completion; the first post-reset cycle is IDLE.
- Bit counter width is $clog2(DATA_W).
- Outputs are decoded combinationally from registered state only; there is no input-to-output combinational path:
  - in_ready = (state == IDLE).
  - ser_valid = (state != IDLE).
  - ser_last = (state == PARITY).
  - ser_out = shreg[0] in SHIFT, acc in PARITY, 0 in IDLE.
- State IDLE:
  - On an edge with in_valid & in_ready: shreg <= in_data, acc <= PARITY_ODD, count <= 0, state <= SHIFT.
  - in_data is ignored whenever in_valid is low.
- State SHIFT:
  - On an edge with ser_ready: acc <= acc ^ shreg[0], shreg <= shreg >> 1, count <= count + 1.
  - If count == DATA_W-1 on that edge, state <= PARITY.
  - With ser_ready=0, all registers hold, so ser_out stays stable for the whole stall.
- State PARITY:
  - ser_out = acc, which equals ^in_data ^ PARITY_ODD.
  - On an edge with ser_ready: state <= IDLE.
  - With ser_ready=0, hold.
- in_valid is ignored in SHIFT and PARITY. The upstream source must hold its word until in_ready is high.
- Latency:
  - The first data bit is valid the cycle after the accept edge.
  - A frame is exactly DATA_W+1 accepted beats.
  - in_ready rises the cycle after the parity beat is accepted.
  - Back-to-back words therefore have one idle cycle between frames; minimum frame period is DATA_W+2 cycles with ser_ready held high.
- ser_ready high in IDLE has no effect.

Test Plan:
1. DATA_W=8, PARITY_ODD=0, in_data=8'hA5, ser_ready=1 -> ser_out sequence 1,0,1,0,0,1,0,1 then parity 0; ser_last high on beat 9 only; in_ready high again the following cycle.
2. in_data=8'h07: with PARITY_ODD=0 the parity beat is 1; with a second instance at PARITY_ODD=1 the parity beat is 0. The 8 data bits are identical in both cases: 1,1,1,0,0,0,0,0.
3. Stall, in_data=8'hA5: drop ser_ready for 3 cycles after the 2nd beat -> ser_out holds 1 (bit 2) and ser_valid stays 1 through the stall. The full frame sequence is unchanged from scenario 1.
4. Drive in_valid=1 with 8'hFF during SHIFT of an 8'h00 frame -> in_ready=0 throughout; the 8'h00 frame completes with parity 0. 8'hFF is accepted only on the first IDLE edge, then sends eight 1s and parity 0.
5. Back-to-back: in_valid held high with 8'h00 then 8'hFF, ser_ready=1 -> exactly one ser_valid=0 cycle between frames; each frame takes 9 beats; both parity beats are 0.
6. Reset during frame: assert rst_n=0 on the 4th beat of 8'hA5 -> ser_valid, ser_out and ser_last go to 0 immediately without waiting for a clock edge, and in_ready=1. After release, a new 8'h07 frame (PARITY_ODD=0) sends cleanly with parity 1.
